// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, stall-bit indices, the queue
// head payload and the sequential-PC helper.
package if_fetch_pkg;

    localparam int unsigned InstAddrW  = 32;
    localparam int unsigned InstW      = 32;
    localparam int unsigned StallW     = 6;
    localparam int unsigned FetchDepth = 4;

    // Bits of the control stall vector that this stage honours
    localparam int unsigned StallIssue = 0;
    localparam int unsigned StallPop   = 1;

    localparam logic [InstW-1:0] ZeroWord = 32'h0000_0000;
    localparam logic             Stop     = 1'b1;
    localparam logic             NoStop   = 1'b0;

    // Head entry handed to IF/ID
    typedef struct packed {
        logic [InstAddrW-1:0] pc;
        logic [InstW-1:0]     inst;
    } fetch_entry_t;

    // Word-sequential next fetch address, wrapping modulo 2^32
    function automatic logic [InstAddrW-1:0] next_pc(input logic [InstAddrW-1:0] pc);
        return pc + InstAddrW'(4);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: pc/inst storage with alloc (tail), fill and pop (head)
// pointers plus per-entry filled flags.
// Ports: clk, rst (async, active-low); clear_i drops every entry;
//        alloc_i/alloc_pc_i reserve the tail; fill_i/fill_inst_i complete the
//        oldest unfilled entry; pop_i retires the head;
//        head_o/head_filled_o present the head; full_o when all entries are
//        allocated; unfilled_o counts allocated entries still awaiting data.
module fetch_queue
    import if_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = FetchDepth,
    localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 alloc_i,
    input  logic [InstAddrW-1:0] alloc_pc_i,
    input  logic                 fill_i,
    input  logic [InstW-1:0]     fill_inst_i,
    input  logic                 pop_i,
    output fetch_entry_t         head_o,
    output logic                 head_filled_o,
    output logic                 full_o,
    output logic [CntW-1:0]      unfilled_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [InstAddrW-1:0] pc_q   [DEPTH];
    logic [InstW-1:0]     inst_q [DEPTH];
    logic [DEPTH-1:0]     filled_q, filled_d;
    logic [PtrW-1:0]      head_q, head_d;
    logic [PtrW-1:0]      tail_q, tail_d;
    logic [PtrW-1:0]      fill_q, fill_d;
    logic [CntW-1:0]      alloc_q, alloc_d;
    logic [CntW-1:0]      filled_cnt;

    // Payload storage; validity is carried by filled_q, so no reset needed
    always_ff @(posedge clk) begin
        if (alloc_i) begin
            pc_q[tail_q] <= alloc_pc_i;
        end
        if (fill_i) begin
            inst_q[fill_q] <= fill_inst_i;
        end
    end

    // Pointer/flag next state. Alloc clears the tail flag and pop clears the
    // head flag; when full with a pop these are the same entry, which is fine.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        fill_d   = fill_q;
        alloc_d  = alloc_q;
        filled_d = filled_q;
        if (clear_i) begin
            head_d   = '0;
            tail_d   = '0;
            fill_d   = '0;
            alloc_d  = '0;
            filled_d = '0;
        end else begin
            if (alloc_i) begin
                tail_d           = tail_q + PtrW'(1);
                filled_d[tail_q] = 1'b0;
            end
            if (fill_i) begin
                fill_d           = fill_q + PtrW'(1);
                filled_d[fill_q] = 1'b1;
            end
            if (pop_i) begin
                head_d           = head_q + PtrW'(1);
                filled_d[head_q] = 1'b0;
            end
            alloc_d = alloc_q + CntW'(alloc_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            fill_q   <= '0;
            alloc_q  <= '0;
            filled_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            fill_q   <= fill_d;
            alloc_q  <= alloc_d;
            filled_q <= filled_d;
        end
    end

    // Filled flags only ever sit on allocated entries
    always_comb begin
        filled_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            filled_cnt = filled_cnt + CntW'(filled_q[i]);
        end
    end

    assign unfilled_o    = alloc_q - filled_cnt;
    assign full_o        = (alloc_q == CntW'(DEPTH));
    assign head_filled_o = filled_q[head_q];
    assign head_o        = '{pc: pc_q[head_q], inst: inst_q[head_q]};

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests to the
// instruction ROM (req/gnt/rvalid), queues returned words with their PCs and
// presents the queue head to IF/ID.
// Ports: clk, rst (async, active-low); stall[0] blocks issue, stall[1] holds
//        the head; flush/new_pc redirect; rom_req_o/rom_addr_o/rom_gnt_i and
//        rom_rvalid_i/rom_rdata_i form the ROM handshake; if_pc/if_inst feed
//        IF/ID (zero when nothing is presented); stallreq_if asks control to
//        stall while the head has no instruction.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrW-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned          DEPTH    = FetchDepth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [StallW-1:0]    stall,
    input  logic                 flush,
    input  logic [InstAddrW-1:0] new_pc,
    output logic                 rom_req_o,
    output logic [InstAddrW-1:0] rom_addr_o,
    input  logic                 rom_gnt_i,
    input  logic                 rom_rvalid_i,
    input  logic [InstW-1:0]     rom_rdata_i,
    output logic [InstAddrW-1:0] if_pc,
    output logic [InstW-1:0]     if_inst,
    output logic                 stallreq_if
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [InstAddrW-1:0] fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0]      drop_cnt_q, drop_cnt_d;
    logic                 alloc_en, fill_en, pop_en;
    logic                 head_filled, full;
    logic [CntW-1:0]      unfilled;
    fetch_entry_t         head;
    logic                 unused_stall;

    assign unused_stall = ^stall[StallW-1:2];

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (flush),
        .alloc_i       (alloc_en),
        .alloc_pc_i    (fetch_pc_q),
        .fill_i        (fill_en),
        .fill_inst_i   (rom_rdata_i),
        .pop_i         (pop_en),
        .head_o        (head),
        .head_filled_o (head_filled),
        .full_o        (full),
        .unfilled_o    (unfilled)
    );

    // Handshake: a pop frees a slot in the same cycle, so a full queue can
    // still issue while draining. rst gating keeps req low during reset.
    assign pop_en    = head_filled && !stall[StallPop] && !flush;
    assign rom_req_o = rst && !stall[StallIssue] && !flush
                       && (drop_cnt_q == '0) && (!full || pop_en);
    assign alloc_en  = rom_req_o && rom_gnt_i;
    assign fill_en   = rom_rvalid_i && (drop_cnt_q == '0) && !flush;

    assign rom_addr_o  = fetch_pc_q;
    assign if_pc       = (head_filled && !flush) ? head.pc   : ZeroWord;
    assign if_inst     = (head_filled && !flush) ? head.inst : ZeroWord;
    assign stallreq_if = (rst && !head_filled) ? Stop : NoStop;

    // On flush every still-outstanding response becomes a drop; a response
    // landing in the flush cycle itself is consumed (dropped) right away.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            fetch_pc_d = new_pc;
            drop_cnt_d = drop_cnt_q + unfilled - CntW'(rom_rvalid_i);
        end else begin
            if (alloc_en) begin
                fetch_pc_d = next_pc(fetch_pc_q);
            end
            if (rom_rvalid_i && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
